// File: rtl/conv3x3_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine.
//   mode_e    : output mode selector (values 5-7 are folded onto MODE_PASS)
//   LATENCY   : cycles from an accepted pixel to its oDVAL
//   saturate  : clamp an unsigned value of in_w bits to out_w bits
package conv3x3_pkg;

  typedef enum logic [2:0] {
    MODE_PASS = 3'd0,
    MODE_GX   = 3'd1,
    MODE_GY   = 3'd2,
    MODE_MAG  = 3'd3,
    MODE_THR  = 3'd4
  } mode_e;

  localparam int LATENCY   = 3;
  localparam int SAT_MAX_W = 32;

  // Bits of val above in_w are ignored; anything not representable in
  // out_w bits becomes the all-ones out_w value.
  function automatic logic [SAT_MAX_W-1:0] saturate(input logic [SAT_MAX_W-1:0] val,
                                                    input int in_w,
                                                    input int out_w);
    logic [SAT_MAX_W-1:0] v;
    logic [SAT_MAX_W-1:0] lim;
    v = val;
    if (in_w < SAT_MAX_W) v = val & ((SAT_MAX_W'(1) << in_w) - 1'b1);
    lim = (SAT_MAX_W'(1) << out_w) - 1'b1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/conv3x3_edge_stream_line_buffer.sv
// Two-tap line delay for the 3x3 window (generic model of the RAM-based
// shift-register megafunction).
//   clock   : clock
//   clken   : advance the delay line by one pixel
//   shiftin : newest pixel
//   taps0x  : pixel LINE_W accepted samples ago (one line above)
//   taps1x  : pixel 2*LINE_W accepted samples ago (two lines above)
// The RAM and pointer have no reset; stale contents are masked downstream
// by the border logic.
module line_buffer_2tap #(
  parameter int DW     = 12,
  parameter int LINE_W = 640
) (
  input  logic          clock,
  input  logic          clken,
  input  logic [DW-1:0] shiftin,
  output logic [DW-1:0] taps0x,
  output logic [DW-1:0] taps1x
);

  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [DW-1:0] r_mem0 [LINE_W];
  logic [DW-1:0] r_mem1 [LINE_W];
  logic [AW-1:0] r_ptr;

  // The slot about to be overwritten holds the sample from exactly one line ago.
  assign taps0x = r_mem0[r_ptr];
  assign taps1x = r_mem1[r_ptr];

  always_ff @(posedge clock) begin
    if (clken) begin
      r_mem0[r_ptr] <= shiftin;
      r_mem1[r_ptr] <= r_mem0[r_ptr];
      r_ptr         <= (r_ptr >= AW'(LINE_W - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv3x3_edge_stream.sv
// Streaming 3x3 Sobel-style convolution with border masking.
//   iCLK, iRST      : clock, asynchronous active-low reset
//   iDATA, iDVAL    : grayscale pixel and its valid strobe
//   iSOF            : start of frame, qualified by iDVAL, marks pixel (0,0)
//   iMODE           : 0 pass, 1 |Gx|, 2 |Gy|, 3 |Gx|+|Gy|, 4 threshold (5-7 = pass)
//   iTHRESH         : magnitude threshold for mode 4, used live
//   oDATA, oDVAL    : result pixel (window centre) and valid, 3 cycles after input
//   oBORDER         : output pixel lies in the two-pixel top/left border
// Mode is latched at SOF and carried with each pixel so in-flight pixels of the
// previous frame finish in the mode they started with.
module conv3x3_edge_stream
  import conv3x3_pkg::*;
#(
  parameter int DW     = 12,
  parameter int LINE_W = 640,
  parameter int CW     = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
  input  logic          iSOF,
  input  logic [2:0]    iMODE,
  input  logic [DW-1:0] iTHRESH,
  output logic [DW-1:0] oDATA,
  output logic          oDVAL,
  output logic          oBORDER
);

  function automatic logic signed [DW+3:0] ext(input logic [DW-1:0] px);
    return signed'({4'b0000, px});
  endfunction

  function automatic logic [DW+2:0] abs_g(input logic signed [DW+3:0] g);
    return (DW+3)'(g[DW+3] ? -g : g);
  endfunction

  function automatic logic [DW-1:0] sat_dw(input logic [DW+3:0] v);
    return DW'(saturate(SAT_MAX_W'(v), DW + 4, DW));
  endfunction

  // ---------------- position and mode tracking ----------------
  logic [CW-1:0] r_col, r_row;
  logic [CW-1:0] w_col, w_row;
  logic          w_sof, w_eol;
  mode_e         r_mode, w_mode_in, w_mode_cur;

  assign w_sof      = iDVAL & iSOF;
  assign w_col      = w_sof ? '0 : r_col;
  assign w_row      = w_sof ? '0 : r_row;
  assign w_eol      = (w_col == CW'(LINE_W - 1));
  assign w_mode_in  = (iMODE > 3'd4) ? MODE_PASS : mode_e'(iMODE);
  assign w_mode_cur = w_sof ? w_mode_in : r_mode;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_col  <= '0;
      r_row  <= '0;
      r_mode <= MODE_PASS;
    end else if (iDVAL) begin
      r_col  <= w_eol ? '0 : w_col + 1'b1;
      // Row saturates instead of wrapping so an over-long frame stays unmasked.
      r_row  <= (w_eol && (w_row != '1)) ? w_row + 1'b1 : w_row;
      r_mode <= w_mode_cur;
    end
  end

  logic [DW-1:0] w_tap0, w_tap1;

  line_buffer_2tap #(
    .DW     (DW),
    .LINE_W (LINE_W)
  ) u_line_buffer (
    .clock   (iCLK),
    .clken   (iDVAL),
    .shiftin (iDATA),
    .taps0x  (w_tap0),
    .taps1x  (w_tap1)
  );

  // ---------------- S1: window shift, border flag ----------------
  logic [2:0][DW-1:0] r_w0_p1, r_w1_p1, r_w2_p1;
  logic               r_bord_p1, r_vld_p1;
  mode_e              r_mode_p1;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_w0_p1   <= '0;
      r_w1_p1   <= '0;
      r_w2_p1   <= '0;
      r_bord_p1 <= 1'b0;
      r_mode_p1 <= MODE_PASS;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= iDVAL;
      if (iDVAL) begin
        r_w0_p1   <= {w_tap1, r_w0_p1[2:1]};
        r_w1_p1   <= {w_tap0, r_w1_p1[2:1]};
        r_w2_p1   <= {iDATA,  r_w2_p1[2:1]};
        r_bord_p1 <= (w_col < CW'(2)) | (w_row < CW'(2));
        r_mode_p1 <= w_mode_cur;
      end
    end
  end

  // ---------------- S2: gradients ----------------
  logic signed [DW+3:0] w_gx, w_gy;
  logic signed [DW+3:0] r_gx_p2, r_gy_p2;
  logic [DW-1:0]        r_cen_p2;
  logic                 r_bord_p2, r_vld_p2;
  mode_e                r_mode_p2;

  assign w_gx = (ext(r_w0_p1[2]) + (ext(r_w1_p1[2]) <<< 1) + ext(r_w2_p1[2]))
              - (ext(r_w0_p1[0]) + (ext(r_w1_p1[0]) <<< 1) + ext(r_w2_p1[0]));
  assign w_gy = (ext(r_w2_p1[0]) + (ext(r_w2_p1[1]) <<< 1) + ext(r_w2_p1[2]))
              - (ext(r_w0_p1[0]) + (ext(r_w0_p1[1]) <<< 1) + ext(r_w0_p1[2]));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_vld_p2 <= 1'b0;
    else       r_vld_p2 <= r_vld_p1;
  end

  always_ff @(posedge iCLK) begin
    r_gx_p2   <= w_gx;
    r_gy_p2   <= w_gy;
    r_cen_p2  <= r_w1_p1[1];
    r_bord_p2 <= r_bord_p1;
    r_mode_p2 <= r_mode_p1;
  end

  // ---------------- S3: magnitude, mode select, output ----------------
  logic [DW+2:0] w_ax, w_ay;
  logic [DW+3:0] w_mag;
  logic          w_thr_hit;
  logic [DW-1:0] w_res;

  assign w_ax      = abs_g(r_gx_p2);
  assign w_ay      = abs_g(r_gy_p2);
  assign w_mag     = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_thr_hit = (w_mag > {4'b0000, iTHRESH});

  always_comb begin
    w_res = '0;
    case (r_mode_p2)
      MODE_GX:  w_res = sat_dw({1'b0, w_ax});
      MODE_GY:  w_res = sat_dw({1'b0, w_ay});
      MODE_MAG: w_res = sat_dw(w_mag);
      MODE_THR: w_res = w_thr_hit ? '1 : '0;
      default:  w_res = r_cen_p2;
    endcase
    // Passthrough keeps border pixels visible; gradient modes zero them.
    if (r_bord_p2 && (r_mode_p2 != MODE_PASS)) w_res = '0;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oBORDER <= 1'b0;
    end else begin
      oDVAL <= r_vld_p2;
      if (r_vld_p2) begin
        oDATA   <= w_res;
        oBORDER <= r_bord_p2;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_edge_stream.sv
module tb_conv3x3_edge_stream;
  import conv3x3_pkg::*;

  localparam int DW = 12;
  localparam int LW = 8;
  localparam int NROWS = 8;

  localparam int P_FLAT = 0, P_VSTEP = 1, P_HSTEP = 2, P_C77 = 3;
  localparam int E_ZERO = 0, E_VSAT = 1, E_H2000 = 2, E_HTHR = 3, E_77 = 4;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic          iSOF;
  logic [2:0]    iMODE;
  logic [DW-1:0] iTHRESH;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic          oBORDER;

  always #5 iCLK = ~iCLK;

  conv3x3_edge_stream #(
    .DW     (DW),
    .LINE_W (LW),
    .CW     (11)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iDATA   (iDATA),
    .iDVAL   (iDVAL),
    .iSOF    (iSOF),
    .iMODE   (iMODE),
    .iTHRESH (iTHRESH),
    .oDATA   (oDATA),
    .oDVAL   (oDVAL),
    .oBORDER (oBORDER)
  );

  typedef struct {
    bit            vld;
    bit            dc;
    logic [DW-1:0] data;
    bit            bord;
    int            id;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            next_id = 0;
  logic [DW-1:0] last_data;
  bit            last_bord;
  bit            last_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_entry(input exp_t e);
    chk($sformatf("dval#%0d", e.id), 32'(oDVAL), 32'(e.vld));
    if (e.vld) begin
      chk($sformatf("border#%0d", e.id), 32'(oBORDER), 32'(e.bord));
      last_bord = e.bord;
      if (!e.dc) begin
        chk($sformatf("data#%0d", e.id), 32'(oDATA), 32'(e.data));
        last_data  = e.data;
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
    end else begin
      chk($sformatf("hold_border#%0d", e.id), 32'(oBORDER), 32'(last_bord));
      if (last_known) chk($sformatf("hold_data#%0d", e.id), 32'(oDATA), 32'(last_data));
    end
  endtask

  // One input cycle; the expectation travels with the pixel and is checked
  // when that pixel reaches the output.
  task automatic step(input logic [DW-1:0] d, input bit v, input bit s,
                      input logic [2:0] m, input logic [DW-1:0] th,
                      input logic [DW-1:0] ed, input bit eb, input bit dc);
    exp_t e;
    @(negedge iCLK);
    iDATA = d; iDVAL = v; iSOF = s; iMODE = m; iTHRESH = th;
    e.vld = v; e.dc = dc; e.data = ed; e.bord = eb; e.id = next_id;
    next_id++;
    q.push_back(e);
    @(posedge iCLK); #1;
    if (q.size() == LATENCY) check_entry(q.pop_front());
  endtask

  task automatic restart_queue();
    exp_t e;
    q.delete();
    e.vld = 1'b0; e.dc = 1'b1; e.data = '0; e.bord = 1'b0; e.id = -1;
    q.push_back(e);
    q.push_back(e);
    last_data = '0; last_bord = 1'b0; last_known = 1'b1;
  endtask

  function automatic logic [DW-1:0] pix_of(input int pat, input int r, input int c);
    case (pat)
      P_FLAT:  return 12'd100;
      P_VSTEP: return (c >= 4) ? 12'd2000 : 12'd0;
      P_HSTEP: return (r >= 4) ? 12'd500 : 12'd0;
      default: return 12'd77;
    endcase
  endfunction

  // Hand-derived results: the centre pixel is (c-1, r-1).
  function automatic logic [DW-1:0] exp_of(input int ek, input int r, input int c);
    bit bord;
    bord = (r < 2) || (c < 2);
    case (ek)
      E_VSAT:  return (!bord && (c - 1 == 3 || c - 1 == 4)) ? 12'd4095 : 12'd0;
      E_H2000: return (!bord && (r - 1 == 3 || r - 1 == 4)) ? 12'd2000 : 12'd0;
      E_HTHR:  return (!bord && (r - 1 == 3 || r - 1 == 4)) ? 12'd4095 : 12'd0;
      E_77:    return 12'd77;
      default: return 12'd0;
    endcase
  endfunction

  task automatic run_frame(input int pat, input logic [2:0] m_sof, input logic [2:0] m_mid,
                           input logic [DW-1:0] th, input int ek);
    for (int r = 0; r < NROWS; r++) begin
      for (int c = 0; c < LW; c++) begin
        step(pix_of(pat, r, c), 1'b1, (r == 0 && c == 0),
             ((r * LW + c) < 32) ? m_sof : m_mid, th,
             exp_of(ek, r, c), (r < 2) || (c < 2), 1'b0);
      end
    end
  endtask

  initial begin
    iRST = 1'b0; iDATA = '0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 3'd0; iTHRESH = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_dval",   32'(oDVAL),   32'd0);
    chk("reset_data",   32'(oDATA),   32'd0);
    chk("reset_border", 32'(oBORDER), 32'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    restart_queue();

    run_frame(P_FLAT,  3'd3, 3'd3, 12'd0,    E_ZERO);
    run_frame(P_VSTEP, 3'd1, 3'd1, 12'd0,    E_VSAT);
    run_frame(P_VSTEP, 3'd2, 3'd2, 12'd0,    E_ZERO);
    run_frame(P_HSTEP, 3'd2, 3'd2, 12'd0,    E_H2000);
    run_frame(P_HSTEP, 3'd4, 3'd4, 12'd1999, E_HTHR);
    run_frame(P_HSTEP, 3'd4, 3'd4, 12'd2000, E_ZERO);
    // iMODE drops to 0 halfway through; the frame must stay in |Gx|.
    run_frame(P_C77,   3'd1, 3'd0, 12'd0,    E_ZERO);
    run_frame(P_C77,   3'd0, 3'd0, 12'd0,    E_77);

    // Mode 5 behaves as passthrough; gap pattern 1,0,0,1 inside the frame.
    for (int i = 0; i < 36; i++) begin
      step(12'd77, 1'b1, (i == 0), 3'd5, 12'd0, 12'd77,
           (i / LW < 2) || (i % LW < 2), 1'b0);
      if (i == 20) begin
        step(12'd0, 1'b0, 1'b0, 3'd5, 12'd0, 12'd0, 1'b0, 1'b0);
        step(12'd0, 1'b0, 1'b0, 3'd5, 12'd0, 12'd0, 1'b0, 1'b0);
      end
    end

    // Asynchronous reset mid-line drops the in-flight pixels at once.
    @(negedge iCLK);
    iRST = 1'b0; iDVAL = 1'b0; iSOF = 1'b0;
    #1;
    chk("midreset_dval",   32'(oDVAL),   32'd0);
    chk("midreset_data",   32'(oDATA),   32'd0);
    chk("midreset_border", 32'(oBORDER), 32'd0);
    @(posedge iCLK); #1;
    chk("inreset_dval", 32'(oDVAL), 32'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    restart_queue();

    // No SOF after reset: active mode stays passthrough despite iMODE=3.
    for (int i = 0; i < 3 * LW; i++) begin
      step(12'd55, 1'b1, 1'b0, 3'd3, 12'd0, 12'd55,
           (i / LW < 2) || (i % LW < 2), (i / LW < 2) || (i % LW < 2));
    end
    repeat (3) step(12'd0, 1'b0, 1'b0, 3'd3, 12'd0, 12'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_edge_stream.md
Name: conv3x3_edge_stream

Overview:
- Parametrised streaming 3x3 convolution engine for the camera path. Sits after the grayscale/Bayer-average stage and before the RGB output mux.
- Generalises the fixed 12-bit Sobel edge path: configurable pixel width and line length, and five selectable modes (passthrough, |Gx|, |Gy|, magnitude, binary threshold).
- Adds explicit border masking, frame-synchronous mode latching, saturation and a fixed-latency valid pipeline.

Parameters:
- DW, 12, pixel data width in bits.
- LINE_W, 640, valid pixels per line; sets line-buffer depth.
- CW, 11, column/row counter width; must satisfy 2^CW >= LINE_W.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous active-low reset.
- iDATA  in  DW  grayscale pixel.
- iDVAL  in  1  iDATA valid; one pixel accepted per cycle when high.
- iSOF  in  1  start of frame; qualified by iDVAL and marks pixel (0,0).
- iMODE  in  3  0 pass, 1 |Gx|, 2 |Gy|, 3 |Gx|+|Gy|, 4 threshold; 5-7 behave as 0.
- iTHRESH  in  DW  threshold for mode 4.
- oDATA  out  DW  result pixel.
- oDVAL  out  1  oDATA valid.
- oBORDER  out  1  current output pixel was masked as border.

Behaviour:
- Reset (iRST low, async): oDATA=0, oDVAL=0, oBORDER=0. Column and row counters, window registers, pipeline valids and the latched mode are cleared to 0. Line-buffer RAM is not cleared.
- Counters advance only on iDVAL.
  - col increments per pixel and wraps LINE_W-1 -> 0; row increments on that wrap.
  - iDVAL&iSOF forces col=0, row=0 for that pixel and resyncs even mid-line.
  - Row saturates at 2^CW-1.
- Mode latch: iMODE is sampled into the active mode on iDVAL&iSOF only. Mid-frame changes take effect at the next frame. After reset the active mode is 0 until the first SOF.
- Line buffer: 2 taps of LINE_W depth, clock-enabled by iDVAL.
  - Tap0 = pixel one line above; tap1 = two lines above.
  - 3x3 window registers shift left on iDVAL.
  - Window rows: w0 = top (tap1), w1 = middle (tap0), w2 = bottom (iDATA).
  - Columns: j=0 oldest, j=2 newest.
- Pipeline (advances every cycle; valid bits tag data). Latency is exactly 3 cycles from iDVAL sample to oDVAL. Gaps in iDVAL yield identical gaps in oDVAL.
  - S1: window update; capture border flag = (col<2)|(row<2) for the incoming pixel.
  - S2: Gx = (w0[2]+2w1[2]+w2[2]) - (w0[0]+2w1[0]+w2[0]); Gy = (w2[0]+2w2[1]+w2[2]) - (w0[0]+2w0[1]+w0[2]). Both are signed DW+4 bits; no overflow is possible.
  - S3: abs of each gives DW+3 bits. Mag = |Gx|+|Gy| in DW+4 bits. Each mode result saturates to 2^DW-1.
- S3 mode outputs:
  - Mode 0: w1[1].
  - Mode 1: sat|Gx|.
  - Mode 2: sat|Gy|.
  - Mode 3: sat(Mag).
  - Mode 4: all-ones if Mag > iTHRESH, else 0. iTHRESH is sampled live at S3, not latched.
- Output alignment: oDATA refers to the window centre, i.e. pixel (col-1, row-1) of the input that entered at S1.
- Border: if the border flag is set, oDATA=0 and oBORDER=1 in every mode except mode 0, which passes w1[1] through with oBORDER=1.
- oDVAL=0 cycles: oDATA and oBORDER hold their previous values.
- Reset mid-frame: in-flight pixels are dropped (oDVAL low the next cycle). Stale line-buffer data is masked because row<2 after reset.
- No backpressure: the downstream stage must accept every oDVAL.

Decomposition:
- Package conv3x3_pkg holds:
  - mode enum: MODE_PASS=0, MODE_GX=1, MODE_GY=2, MODE_MAG=3, MODE_THR=4;
  - LATENCY=3 constant;
  - a saturate function parametrised on input width.
- One sub-module: line_buffer_2tap (params DW, LINE_W; ports clock, clken, shiftin, taps0x, taps1x). It wraps the RAM shift-register megafunction so the core stays technology-independent.

Test Plan:
- DW=12, LINE_W=8 for all scenarios.
- Flat frame: all pixels 100, mode 3. Rows 0-1 and cols 0-1 give oDATA=0 with oBORDER=1; all others give oDATA=0 with oBORDER=0. oDVAL follows iDVAL exactly 3 cycles later.
- Vertical step: cols 0-3 = 0, cols 4-7 = 2000, mode 1. Output centre cols 3 and 4 give 4095 (Gx=8000, saturated); centre col 5 gives 0. Mode 2 gives 0 everywhere.
- Horizontal step: rows 0-3 = 0, rows 4+ = 500, mode 2. Output centre rows 3 and 4 give 2000. Mode 4 with iTHRESH=1999 gives 4095; with iTHRESH=2000 gives 0.
- Mode latch: switch iMODE 1->0 at mid-frame. Output stays mode 1 until the next iSOF, then passes w1[1] through (input 77 -> output 77 at 3-cycle latency).
- Gapped valid and reset: toggle iDVAL 1,0,0,1 and check that the same pattern appears on oDVAL 3 cycles later. Then pull iRST low mid-line: oDVAL=0 and oDATA=0 immediately, and the first two post-reset rows report oBORDER=1.
